pipe_ctrl_sequencer: RTL and testbench

- Sequences the decoded control bundles (WB[1:0], M[2:0], EX[3:0]) from the ID-stage decoder through the ID/EX, EX/MEM and MEM/WB control registers of the 5-stage pipeline.
- Detects load-use hazards and inserts bubbles, flushes on a taken branch, and freezes the pipeline on data-memory wait.
- Drives pc_write and if_id_write. Sits between the decoder and the datapath pipeline registers.

---
 rtl/pipe_ctrl_sequencer.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_sequencer.sv
// Control-bundle sequencer for a 5-stage pipeline: load-use bubbles, branch flush, dmem freeze.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_sequencer #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [1:0]       wb_in_i,
  input  logic [2:0]       m_in_i,
  input  logic [3:0]       ex_in_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             mem_zero_i,
  input  logic             dmem_wait_i,
  output logic [3:0]       ex_ctrl_o,
  output logic [2:0]       mem_ctrl_o,
  output logic [1:0]       wb_ctrl_o,
  output logic [REG_W-1:0] ex_dest_o,
  output logic [REG_W-1:0] mem_dest_o,
  output logic [REG_W-1:0] wb_dest_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             pc_src_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // ID/EX carries the full bundle, EX/MEM drops EX bits, MEM/WB keeps only WB bits.
  logic [3:0]       idex_ex_q, idex_ex_d;
  logic [2:0]       idex_m_q, idex_m_d;
  logic [1:0]       idex_wb_q, idex_wb_d;
  logic [REG_W-1:0] idex_dest_q, idex_dest_d;
  logic [2:0]       exmem_m_q, exmem_m_d;
  logic [1:0]       exmem_wb_q, exmem_wb_d;
  logic [REG_W-1:0] exmem_dest_q, exmem_dest_d;
  logic [1:0]       memwb_wb_q, memwb_wb_d;
  logic [REG_W-1:0] memwb_dest_q, memwb_dest_d;

  logic [REG_W-1:0] id_dest;
  logic             uses_rt;
  logic             branch_taken;
  logic             load_use;
  logic             do_flush;
  logic             do_stall;

  assign id_dest      = ex_in_i[3] ? id_rd_i : id_rt_i;
  // rt is a source for R-type, beq and sw; for loads and immediates it is the destination.
  assign uses_rt      = ex_in_i[3] | m_in_i[2] | m_in_i[0];
  assign branch_taken = exmem_m_q[2] & mem_zero_i;
  assign load_use     = id_valid_i & idex_m_q[1] & (idex_dest_q != '0) &
                        ((idex_dest_q == id_rs_i) | (uses_rt & (idex_dest_q == id_rt_i)));
  assign do_flush     = ~dmem_wait_i & branch_taken;
  assign do_stall     = ~dmem_wait_i & ~branch_taken & load_use;

  assign pc_write_o    = ~dmem_wait_i & ~do_stall;
  assign if_id_write_o = ~dmem_wait_i & ~do_stall;
  assign pc_src_o      = do_flush;
  assign if_id_flush_o = do_flush;

  always_comb begin
    idex_ex_d    = idex_ex_q;
    idex_m_d     = idex_m_q;
    idex_wb_d    = idex_wb_q;
    idex_dest_d  = idex_dest_q;
    exmem_m_d    = exmem_m_q;
    exmem_wb_d   = exmem_wb_q;
    exmem_dest_d = exmem_dest_q;
    memwb_wb_d   = memwb_wb_q;
    memwb_dest_d = memwb_dest_q;
    if (!dmem_wait_i) begin
      memwb_wb_d   = exmem_wb_q;
      memwb_dest_d = exmem_dest_q;
      if (do_flush) begin
        exmem_m_d    = '0;
        exmem_wb_d   = '0;
        exmem_dest_d = '0;
      end else begin
        exmem_m_d    = idex_m_q;
        exmem_wb_d   = idex_wb_q;
        exmem_dest_d = idex_dest_q;
      end
      if (do_flush || do_stall || !id_valid_i) begin
        idex_ex_d   = '0;
        idex_m_d    = '0;
        idex_wb_d   = '0;
        idex_dest_d = '0;
      end else begin
        idex_ex_d   = ex_in_i;
        idex_m_d    = m_in_i;
        idex_wb_d   = wb_in_i;
        idex_dest_d = id_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ex_q    <= '0;
      idex_m_q     <= '0;
      idex_wb_q    <= '0;
      idex_dest_q  <= '0;
      exmem_m_q    <= '0;
      exmem_wb_q   <= '0;
      exmem_dest_q <= '0;
      memwb_wb_q   <= '0;
      memwb_dest_q <= '0;
    end else begin
      idex_ex_q    <= idex_ex_d;
      idex_m_q     <= idex_m_d;
      idex_wb_q    <= idex_wb_d;
      idex_dest_q  <= idex_dest_d;
      exmem_m_q    <= exmem_m_d;
      exmem_wb_q   <= exmem_wb_d;
      exmem_dest_q <= exmem_dest_d;
      memwb_wb_q   <= memwb_wb_d;
      memwb_dest_q <= memwb_dest_d;
    end
  end

  assign ex_ctrl_o  = idex_ex_q;
  assign mem_ctrl_o = exmem_m_q;
  assign wb_ctrl_o  = memwb_wb_q;
  assign ex_dest_o  = idex_dest_q;
  assign mem_dest_o = exmem_dest_q;
  assign wb_dest_o  = memwb_dest_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // do_stall/do_flush already exclude frozen cycles, so counters hold during a freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (do_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (do_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Self-checking bench for pipe_ctrl_sequencer: write-back scoreboard plus per-scenario checks.
module tb_pipe_ctrl_sequencer;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;
`ifdef PIPE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [1:0]       wb_in = '0;
  logic [2:0]       m_in = '0;
  logic [3:0]       ex_in = '0;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic             mem_zero = 1'b0;
  logic             dmem_wait = 1'b0;
  logic [3:0]       ex_ctrl;
  logic [2:0]       mem_ctrl;
  logic [1:0]       wb_ctrl;
  logic [REG_W-1:0] ex_dest, mem_dest, wb_dest;
  logic             pc_write, if_id_write, if_id_flush, pc_src;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]       wb;
    logic [REG_W-1:0] dest;
  } wb_rec_t;
  wb_rec_t sb[$];
  logic    adv;

  pipe_ctrl_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .wb_in_i(wb_in), .m_in_i(m_in),
    .ex_in_i(ex_in), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .mem_zero_i(mem_zero), .dmem_wait_i(dmem_wait), .ex_ctrl_o(ex_ctrl),
    .mem_ctrl_o(mem_ctrl), .wb_ctrl_o(wb_ctrl), .ex_dest_o(ex_dest), .mem_dest_o(mem_dest),
    .wb_dest_o(wb_dest), .pc_write_o(pc_write), .if_id_write_o(if_id_write),
    .if_id_flush_o(if_id_flush), .pc_src_o(pc_src), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  // MEM/WB was loaded at the last edge unless the pipe was frozen.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) adv <= 1'b0;
    else        adv <= ~dmem_wait;
  end

  always @(negedge clk) begin
    if (rst_n && adv && wb_ctrl[1]) begin
      wb_rec_t exp_r;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL writeback_unexpected: got wb=%b dest=%0d, required none", wb_ctrl, wb_dest);
      end else begin
        exp_r = sb.pop_front();
        if ({wb_ctrl, wb_dest} !== exp_r) begin
          errors++;
          $display("FAIL writeback_order: got wb=%b dest=%0d, required wb=%b dest=%0d",
                   wb_ctrl, wb_dest, exp_r.wb, exp_r.dest);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic [REG_W-1:0] rd, input bit retires);
    id_valid = 1'b1;
    wb_in = wb; m_in = m; ex_in = ex;
    id_rs = rs; id_rt = rt; id_rd = rd;
    if (retires) sb.push_back({wb, (ex[3] ? rd : rt)});
  endtask

  task automatic nop();
    id_valid = 1'b0;
    wb_in = '0; m_in = '0; ex_in = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  task automatic do_reset();
    nop();
    mem_zero = 1'b0;
    dmem_wait = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    nop();
    repeat (5) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending writebacks, required 0", name, sb.size());
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl, ex_dest, mem_dest, wb_dest, pc_write, if_id_write,
         if_id_flush, pc_src, stall_cnt, flush_cnt} !==
        {9'd0, {3*REG_W{1'b0}}, 4'b1100, {2*CNT_W{1'b0}}}) begin
      errors++;
      $display("FAIL %s: got ex=%b mem=%b wb=%b dests=%0d/%0d/%0d pcw=%b ifw=%b fl=%b src=%b sc=%0d fc=%0d, required zeros with pcw=1 ifw=1",
               name, ex_ctrl, mem_ctrl, wb_ctrl, ex_dest, mem_dest, wb_dest, pc_write,
               if_id_write, if_id_flush, pc_src, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset();
    #3;
    check_reset_vals("reset_state");
    do_reset();
  endtask

  task automatic test_rtype();
    do_reset();
    issue(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    nop();
    #2;
    checks++;
    if ({ex_ctrl, ex_dest} !== {4'b1100, 5'd3}) begin
      errors++; $display("FAIL rtype_ex: got %b/%0d, required 1100/3", ex_ctrl, ex_dest);
    end
    tick(); #2;
    checks++;
    if ({mem_ctrl, mem_dest, ex_ctrl} !== {3'b000, 5'd3, 4'b0000}) begin
      errors++; $display("FAIL rtype_mem: got %b/%0d ex=%b, required 000/3 ex=0000",
                         mem_ctrl, mem_dest, ex_ctrl);
    end
    tick(); #2;
    checks++;
    if ({wb_ctrl, wb_dest} !== {2'b10, 5'd3}) begin
      errors++; $display("FAIL rtype_wb: got %b/%0d, required 10/3", wb_ctrl, wb_dest);
    end
    drain("rtype");
  endtask

  task automatic test_load_use();
    do_reset();
    issue(2'b11, 3'b010, 4'b0001, 5'd0, 5'd2, 5'd0, 1'b1);
    tick();
    issue(2'b10, 3'b000, 4'b1100, 5'd2, 5'd4, 5'd5, 1'b1);
    #2;
    checks++;
    if ({pc_write, if_id_write} !== 2'b00) begin
      errors++; $display("FAIL loaduse_stall: got pcw=%b ifw=%b, required 0 0", pc_write, if_id_write);
    end
    tick(); #2;
    checks++;
    if ({ex_ctrl, pc_write, mem_ctrl} !== {4'b0000, 1'b1, 3'b010}) begin
      errors++; $display("FAIL loaduse_bubble: got ex=%b pcw=%b mem=%b, required 0000 1 010",
                         ex_ctrl, pc_write, mem_ctrl);
    end
    tick();
    nop();
    #2;
    checks++;
    if ({ex_ctrl, ex_dest, stall_cnt} !== {4'b1100, 5'd5, CNT_W'(PERF)}) begin
      errors++; $display("FAIL loaduse_resume: got ex=%b dest=%0d sc=%0d, required 1100/5 sc=%0d",
                         ex_ctrl, ex_dest, stall_cnt, PERF);
    end
    // second load: invalid ID and an immediate reading only rs must not stall
    issue(2'b11, 3'b010, 4'b0001, 5'd0, 5'd2, 5'd0, 1'b1);
    tick();
    nop();
    id_rs = 5'd2; id_rt = 5'd2;
    #2;
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL loaduse_invalid_id: got pcw=%b, required 1", pc_write);
    end
    issue(2'b10, 3'b000, 4'b0001, 5'd3, 5'd2, 5'd0, 1'b1);
    #2;
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL loaduse_itype_rt: got pcw=%b, required 1", pc_write);
    end
    tick();
    drain("loaduse");
  endtask

  task automatic test_branch(input bit taken);
    do_reset();
    issue(2'b00, 3'b100, 4'b0010, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    issue(2'b10, 3'b000, 4'b1100, 5'd8, 5'd9, 5'd6, !taken);
    tick();
    issue(2'b10, 3'b000, 4'b1100, 5'd8, 5'd9, 5'd7, !taken);
    mem_zero = taken;
    #2;
    checks++;
    if ({pc_src, if_id_flush, pc_write} !== {taken, taken, 1'b1}) begin
      errors++; $display("FAIL branch_ctrl%0d: got src=%b fl=%b pcw=%b, required %b %b 1",
                         taken, pc_src, if_id_flush, pc_write, taken, taken);
    end
    tick();
    mem_zero = 1'b0;
    issue(2'b10, 3'b000, 4'b1100, 5'd8, 5'd9, 5'd10, 1'b1);
    #2;
    checks++;
    if (taken) begin
      if ({ex_ctrl, mem_ctrl, wb_ctrl, pc_src, flush_cnt} !==
          {4'b0000, 3'b000, 2'b00, 1'b0, CNT_W'(PERF)}) begin
        errors++; $display("FAIL branch_flush: got ex=%b mem=%b wb=%b src=%b fc=%0d, required 0 0 0 0 fc=%0d",
                           ex_ctrl, mem_ctrl, wb_ctrl, pc_src, flush_cnt, PERF);
      end
    end else begin
      if ({ex_ctrl, ex_dest, mem_dest, flush_cnt} !==
          {4'b1100, 5'd7, 5'd6, CNT_W'(0)}) begin
        errors++; $display("FAIL branch_nottaken: got ex=%b dests=%0d/%0d fc=%0d, required 1100 7/6 fc=0",
                           ex_ctrl, ex_dest, mem_dest, flush_cnt);
      end
    end
    tick();
    drain(taken ? "branch_taken" : "branch_nottaken");
  endtask

  task automatic test_freeze();
    do_reset();
    issue(2'b11, 3'b010, 4'b0001, 5'd0, 5'd2, 5'd0, 1'b1);
    tick();
    issue(2'b10, 3'b000, 4'b1100, 5'd7, 5'd0, 5'd8, 1'b1);
    tick();
    issue(2'b10, 3'b000, 4'b1100, 5'd7, 5'd6, 5'd9, 1'b1);
    dmem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_wait = 1'b0;
      #2;
      checks++;
      if ({ex_ctrl, ex_dest, mem_ctrl, mem_dest, wb_ctrl, pc_write, if_id_write} !==
          {4'b1100, 5'd8, 3'b010, 5'd2, 2'b00, (i == 3), (i == 3)}) begin
        errors++; $display("FAIL freeze_hold%0d: got ex=%b/%0d mem=%b/%0d wb=%b pcw=%b ifw=%b",
                           i, ex_ctrl, ex_dest, mem_ctrl, mem_dest, wb_ctrl, pc_write, if_id_write);
      end
      if (i < 3) tick();
    end
    tick();
    nop();
    #2;
    checks++;
    if ({ex_dest, mem_dest, wb_dest} !== {5'd9, 5'd8, 5'd2}) begin
      errors++; $display("FAIL freeze_resume: got dests %0d/%0d/%0d, required 9/8/2",
                         ex_dest, mem_dest, wb_dest);
    end
    drain("freeze");
  endtask

  task automatic test_branch_over_loaduse();
    do_reset();
    issue(2'b00, 3'b100, 4'b0010, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    issue(2'b11, 3'b010, 4'b0001, 5'd0, 5'd2, 5'd0, 1'b0);
    tick();
    issue(2'b10, 3'b000, 4'b1100, 5'd2, 5'd4, 5'd5, 1'b0);
    mem_zero = 1'b1;
    #2;
    checks++;
    if ({pc_write, if_id_write, pc_src, if_id_flush} !== 4'b1111) begin
      errors++; $display("FAIL combo_ctrl: got pcw=%b ifw=%b src=%b fl=%b, required 1111",
                         pc_write, if_id_write, pc_src, if_id_flush);
    end
    tick();
    mem_zero = 1'b0;
    nop();
    #2;
    checks++;
    if ({ex_ctrl, mem_ctrl, stall_cnt, flush_cnt} !==
        {4'b0000, 3'b000, CNT_W'(0), CNT_W'(PERF)}) begin
      errors++; $display("FAIL combo_after: got ex=%b mem=%b sc=%0d fc=%0d, required 0 0 sc=0 fc=%0d",
                         ex_ctrl, mem_ctrl, stall_cnt, flush_cnt, PERF);
    end
    drain("combo");
  endtask

  task automatic test_mid_reset();
    do_reset();
    issue(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    issue(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd4, 1'b0);
    tick();
    issue(2'b11, 3'b010, 4'b0001, 5'd0, 5'd2, 5'd0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset_async");
    tick();
    rst_n = 1'b1;
    drain("midreset");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_branch(1'b1);
    test_branch(1'b0);
    test_freeze();
    test_branch_over_loaduse();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
